// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between core control path and muldiv_sequencer.
// Signals: req_valid, funct3, op_a, op_b, kill (core->unit); stall, resp_valid, result (unit->core).
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             kill;
  logic             stall;
  logic             resp_valid;
  logic [WIDTH-1:0] result;

  modport master (
    output req_valid, funct3, op_a, op_b, kill,
    input  stall, resp_valid, result
  );

  modport slave (
    input  req_valid, funct3, op_a, op_b, kill,
    output stall, resp_valid, result
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative radix-2 RV32M MUL/DIV/REM unit, WIDTH iterations per op.
// Ports: clk, reset_n (async low), bus (muldiv_if.slave). Option: MULDIV_CACHE_EN.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input logic     clk,
  input logic     reset_n,
  muldiv_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // div: low half = quotient, high half = remainder
  // mul: MUL takes low word, the rest take high word
  function automatic logic [WIDTH-1:0] sel(
    input logic [2:0]         f,
    input logic [2*WIDTH-1:0] v
  );
    if (f[2])
      return f[1] ? v[2*WIDTH-1:WIDTH] : v[WIDTH-1:0];
    else
      return (f[1:0] == 2'b00) ? v[WIDTH-1:0] : v[2*WIDTH-1:WIDTH];
  endfunction

  logic [1:0]         state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2:0]         f3_q;
  logic               neg_a_q;
  logic               neg_b_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   result_q;

  logic [2:0]       f3;
  logic             is_div;
  logic             sgn_a;
  logic             sgn_b;
  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             div0;
  logic             ovf;
  logic             special;
  logic [WIDTH-1:0] spec_res;
  logic             accept;
  logic [2:0]       cls;
  logic             hit;
  logic [WIDTH-1:0] hit_res;

  assign f3 = bus.funct3;

  always_comb begin
    is_div = f3[2];
    sgn_a  = 1'b0;
    sgn_b  = 1'b0;
    unique case (1'b1)
      is_div: begin
        sgn_a = ~f3[0];
        sgn_b = ~f3[0];
      end
      (!is_div && f3[1:0] == 2'b10): begin
        sgn_a = 1'b1;
      end
      (!is_div && f3[1:0] == 2'b11): begin
        sgn_a = 1'b0;
      end
      default: begin
        sgn_a = 1'b1;
        sgn_b = 1'b1;
      end
    endcase
    neg_a = sgn_a & bus.op_a[WIDTH-1];
    neg_b = sgn_b & bus.op_b[WIDTH-1];
    // -MIN_NEG wraps to MIN_NEG, read as unsigned 2^(WIDTH-1)
    mag_a = neg_a ? -bus.op_a : bus.op_a;
    mag_b = neg_b ? -bus.op_b : bus.op_b;
    div0  = is_div && (bus.op_b == '0);
    ovf   = is_div && !f3[0] &&
            (bus.op_a == MIN_NEG) && (bus.op_b == '1);
    special = div0 || ovf;
    if (div0)
      spec_res = f3[1] ? bus.op_a : '1;
    else
      spec_res = f3[1] ? '0 : MIN_NEG;
    cls = {is_div, sgn_a, sgn_b};
  end

  assign accept = (state_q == IDLE) && bus.req_valid && !bus.kill;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     part;
  logic               div_ge;
  logic [WIDTH-1:0]   div_sub;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   rem_step;

  always_comb begin
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
              {1'b0, (acc_q[0] ? mcand_q : '0)};
    part    = {rem_q, acc_q[WIDTH-1]};
    div_ge  = part >= {1'b0, mcand_q};
    div_sub = part[WIDTH-1:0] - mcand_q;
    if (f3_q[2]) begin
      acc_step = {acc_q[2*WIDTH-1:WIDTH],
                  acc_q[WIDTH-2:0], div_ge};
      // a failed trial leaves part < divisor, so it fits WIDTH bits
      rem_step = div_ge ? div_sub : part[WIDTH-1:0];
    end else begin
      acc_step = {mul_sum, acc_q[WIDTH-1:1]};
      rem_step = rem_q;
    end
  end

  logic               flip;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   q_mag;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rmd;
  logic [2*WIDTH-1:0] v_fix;

  always_comb begin
    flip  = neg_a_q ^ neg_b_q;
    prod  = flip ? -acc_q : acc_q;
    q_mag = acc_q[WIDTH-1:0];
    quo   = flip ? -q_mag : q_mag;
    rmd   = neg_a_q ? -rem_q : rem_q;
    v_fix = f3_q[2] ? {rmd, quo} : prod;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      mcand_q  <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      result_q <= '0;
    end else if (bus.kill) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            f3_q    <= f3;
            neg_a_q <= neg_a;
            neg_b_q <= neg_b;
            mcand_q <= mag_b;
            acc_q   <= {{WIDTH{1'b0}}, mag_a};
            rem_q   <= '0;
            cnt_q   <= '0;
            if (special) begin
              result_q <= spec_res;
              state_q  <= DONE;
            end else if (hit) begin
              result_q <= hit_res;
              state_q  <= DONE;
            end else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          acc_q <= acc_step;
          rem_q <= rem_step;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST)
            state_q <= FIX;
        end
        FIX: begin
          result_q <= sel(f3_q, v_fix);
          state_q  <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef MULDIV_CACHE_EN
  logic               c_valid;
  logic [WIDTH-1:0]   c_a;
  logic [WIDTH-1:0]   c_b;
  logic [2:0]         c_cls;
  logic [2*WIDTH-1:0] c_val;
  logic [WIDTH-1:0]   k_a;
  logic [WIDTH-1:0]   k_b;
  logic [2:0]         k_cls;
  logic [2*WIDTH-1:0] fix_q;
  logic               upd_q;

  assign hit = c_valid && (c_a == bus.op_a) &&
               (c_b == bus.op_b) && (c_cls == cls);
  assign hit_res = sel(f3, c_val);

  // entry is committed only when DONE survives without kill
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c_valid <= 1'b0;
      c_a     <= '0;
      c_b     <= '0;
      c_cls   <= '0;
      c_val   <= '0;
      k_a     <= '0;
      k_b     <= '0;
      k_cls   <= '0;
      fix_q   <= '0;
      upd_q   <= 1'b0;
    end else if (bus.kill) begin
      upd_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          upd_q <= 1'b0;
          if (bus.req_valid && !special && !hit) begin
            k_a   <= bus.op_a;
            k_b   <= bus.op_b;
            k_cls <= cls;
          end
        end
        FIX: begin
          fix_q <= v_fix;
          upd_q <= 1'b1;
        end
        DONE: begin
          upd_q <= 1'b0;
          if (upd_q) begin
            c_valid <= 1'b1;
            c_a     <= k_a;
            c_b     <= k_b;
            c_cls   <= k_cls;
            c_val   <= fix_q;
          end
        end
        default: begin
        end
      endcase
    end
  end
`else
  assign hit     = 1'b0;
  assign hit_res = '0;
`endif

  assign bus.stall = accept ||
    (!bus.kill && (state_q == CALC || state_q == FIX));
  assign bus.resp_valid = (state_q == DONE) && !bus.kill;
  assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed + random checks of muldiv_sequencer
// against a plain-arithmetic RV32M model, including latency and stall.
module tb_muldiv_sequencer;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  muldiv_if #(.WIDTH(W)) bus ();

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit          c_valid = 1'b0;
  logic [31:0] c_a = '0;
  logic [31:0] c_b = '0;
  logic [2:0]  c_cls = '0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] f,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int ia, ib;
    bit ov;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    ia = $signed(a);
    ib = $signed(b);
    ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ov) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ov) return 32'h0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // operation class: {div, signed a, signed b}; MUL low word is
  // sign-agnostic and shares the MULH class
  function automatic logic [2:0] cls_of(input logic [2:0] f);
    case (f)
      3'd0, 3'd1: return 3'b011;
      3'd2:       return 3'b010;
      3'd3:       return 3'b000;
      3'd4, 3'd6: return 3'b111;
      default:    return 3'b100;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f,
                                    input logic [31:0] a,
                                    input logic [31:0] b);
    return f[2] && ((b == 0) ||
      (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
    end
  endtask

  // drives at posedge+1, samples at posedge+2; leaves req held in DONE
  task automatic run_op(input logic [2:0] f,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input string tag);
    int exp_lat;
    int lat;
    logic [31:0] exp;
    bit stall_ok;
    bit hit;
    exp = ref_res(f, a, b);
    hit = 1'b0;
`ifdef MULDIV_CACHE_EN
    hit = c_valid && c_a == a && c_b == b && c_cls == cls_of(f);
`endif
    exp_lat = (is_special(f, a, b) || hit) ? 1 : W + 2;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1;
    bus.funct3 = f;
    bus.op_a = a;
    bus.op_b = b;
    #1;
    stall_ok = (bus.stall === 1'b1);
    lat = -1;
    for (int n = 1; n <= W + 10; n++) begin
      @(posedge clk);
      #2;
      if (bus.resp_valid === 1'b1) begin
        lat = n;
        break;
      end
      if (bus.stall !== 1'b1) stall_ok = 1'b0;
    end
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " stall"}, 64'(stall_ok), 64'd1);
    chk({tag, " result"}, 64'(bus.result), 64'(exp));
    chk({tag, " done_stall"}, 64'(bus.stall), 64'd0);
    if (!is_special(f, a, b)) begin
      c_valid = 1'b1;
      c_a = a;
      c_b = b;
      c_cls = cls_of(f);
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [2:0] rf;
    bit seen;
    bus.req_valid = 1'b0;
    bus.funct3 = 3'd0;
    bus.op_a = '0;
    bus.op_b = '0;
    bus.kill = 1'b0;

    #12;
    chk("rst stall", 64'(bus.stall), 64'd0);
    chk("rst resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst result", 64'(bus.result), 64'd0);
    reset_n = 1'b1;

    run_op(3'd0, 32'd7, 32'd6, "mul_7x6");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_ff");
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, "mulh_min");
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_ff");
    run_op(3'd0, 32'hFFFF_FFFD, 32'd5, "mul_neg3x5");
    run_op(3'd1, 32'hFFFF_FFFD, 32'd5, "mulh_neg3x5");
    idle(2);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
    run_op(3'd5, 32'd100, 32'd7, "divu_100_7");
    run_op(3'd7, 32'd100, 32'd7, "remu_100_7");
    run_op(3'd5, 32'd9, 32'd0, "divu_by0");
    run_op(3'd6, 32'd5, 32'd0, "rem_by0");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
    idle(1);
    run_op(3'd4, 32'd100, 32'd7, "div_100_7");
    run_op(3'd6, 32'd100, 32'd7, "rem_100_7");
    run_op(3'd6, 32'd100, 32'd8, "rem_100_8");
    idle(1);

    // kill mid-iteration
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1;
    bus.funct3 = 3'd5;
    bus.op_a = 32'd1000;
    bus.op_b = 32'd3;
    repeat (11) @(posedge clk);
    #2;
    chk("kill pre_stall", 64'(bus.stall), 64'd1);
    #1;
    bus.kill = 1'b1;
    bus.req_valid = 1'b0;
    #1;
    chk("kill stall", 64'(bus.stall), 64'd0);
    chk("kill resp_valid", 64'(bus.resp_valid), 64'd0);
    @(posedge clk);
    #1;
    bus.kill = 1'b0;
    #1;
    chk("kill idle_stall", 64'(bus.stall), 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #2;
      if (bus.resp_valid === 1'b1) seen = 1'b1;
    end
    chk("kill no_resp", 64'(seen), 64'd0);
    run_op(3'd5, 32'd1000, 32'd3, "after_kill");
    idle(1);

    // async reset mid-iteration
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1;
    bus.funct3 = 3'd3;
    bus.op_a = 32'h1234_5678;
    bus.op_b = 32'h9ABC_DEF0;
    repeat (21) @(posedge clk);
    #3;
    reset_n = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    chk("arst stall", 64'(bus.stall), 64'd0);
    chk("arst resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("arst result", 64'(bus.result), 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    c_valid = 1'b0;
    run_op(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, "after_rst");

    ra = 32'd0;
    rb = 32'd1;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        ra = pick();
        rb = pick();
      end
      rf = 3'($urandom_range(0, 7));
      run_op(rf, ra, rb, "rnd");
      if ($urandom_range(0, 2) == 0) idle(1);
    end
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Iterative multi-cycle sequencer for the RV32M MUL/DIV/REM family, beside the single-cycle ALU. It accepts an operation from the decode/ALU control path and stalls the core while a radix-2 shift-add/shift-subtract datapath runs. It returns one result word when the operation finishes. It is the only multi-cycle execution resource in the processor.

Parameters:
WIDTH, 32, operand/result width; iteration count equals WIDTH
CNT_W, $clog2(WIDTH), iteration counter width (derived, not overridden)

Ports:
clk  in  1  core clock, rising edge
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  current instruction is OP with Funct7=0000001; held stable by core while stall=1
funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op_a  in  WIDTH  rs1 value
op_b  in  WIDTH  rs2 value
kill  in  1  flush; abandons any operation in progress
stall  out  1  freeze PC/pipeline register writes
resp_valid  out  1  result valid; one-cycle pulse
result  out  WIDTH  rd write data, valid while resp_valid=1

Behaviour:
- Reset (reset_n low, async): state=IDLE, counter=0, stall=0, resp_valid=0, result=0, all internal registers 0.
- States: IDLE, CALC, FIX, DONE.
- IDLE: if req_valid && !kill, capture funct3, operand magnitudes and sign flags, then go to CALC. If a special case applies, go directly to DONE instead.
- Signedness: MULH uses signed×signed. MULHSU uses signed op_a × unsigned op_b. DIV/REM use signed operands. Operands are converted to magnitudes on capture.
- CALC: one iteration per cycle for exactly WIDTH cycles (counter 0..WIDTH-1), then go to FIX.
  - Mul: 2·WIDTH-bit accumulator, add-and-shift.
  - Div: restoring division, WIDTH-bit quotient and WIDTH+1-bit partial remainder.
- FIX: apply sign correction, then go to DONE.
  - Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ.
  - Remainder takes the dividend's sign.
  - Select the result: MUL takes the low word; MULH/MULHSU/MULHU take the high word.
- DONE: resp_valid=1 and result is driven for one cycle, stall=0; next state is IDLE. resp_valid is 0 in all other states.
- Latency: request accepted at cycle T gives resp_valid at T+WIDTH+2 (T+34 for WIDTH=32).
- Special cases (no iteration; DONE at T+1):
  - Divisor=0: DIV/DIVU give all-ones; REM/REMU give op_a.
  - Signed overflow (op_a=0x80000000, op_b=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- stall = (state==IDLE && req_valid && !kill) || state==CALC || state==FIX. stall is 0 in DONE so the core retires the instruction in that cycle.
- No re-acceptance in DONE even though req_valid is still high. The next instruction is sampled in the following IDLE cycle, so back-to-back requests are allowed.
- kill in any state: go to IDLE next cycle, no resp_valid, stall=0 combinationally that cycle. kill has priority over acceptance and completion, including in DONE, where resp_valid is forced to 0.
- Async reset during CALC/FIX/DONE: immediate return to reset values; the operation is lost.
- Arithmetic is modulo 2^WIDTH. The negation of 0x80000000 yields 0x80000000, and magnitude logic treats it as unsigned 2^31.

Optional Feature:
MULDIV_CACHE_EN: when defined, keep the last completed operation in a cache.
- Cached data:
  - op_a, op_b and the operation class (mul signedness pair, or div signed/unsigned).
  - Both the full 2·WIDTH product, or both quotient and remainder.
- Hit: a request whose operands and class match gives DONE at T+1 with the cached value. Examples: DIV followed by REM on the same operands, or MUL followed by MULH.
- Invalidation: reset invalidates the cache. A killed operation does not update it.
- Special-case results are not cached.
- When undefined, there is no cache storage and every request has the latencies above.

Test Plan:
- MUL 7×6, then MULHU 0xFFFFFFFF×0xFFFFFFFF → result 42 with resp_valid exactly at T+34 and stall high T..T+33; then 0xFFFFFFFE.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF. MUL 0xFFFFFFFD×5 → 0xFFFFFFF1.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2. Each takes 34 cycles.
- DIVU 9/0 → 0xFFFFFFFF; REM 5/0 → 5; DIV 0x80000000/−1 → 0x80000000; REM 0x80000000/−1 → 0. Each has resp_valid at T+1.
- kill at CALC cycle 10 → IDLE next cycle, no resp_valid, stall low. reset_n low at CALC cycle 20 → stall, resp_valid and result go to 0 immediately; the next request then completes normally.
- With MULDIV_CACHE_EN: DIV 100/7 (34 cycles), then REM 100/7 → 2 at T+1; REM 100/8 → full 34 cycles. Without the macro, both take 34 cycles.
